// File: rtl/muldiv_pkg.sv
// Shared multiply/divide op encodings (funct3 order) and unit-internal types.
// Decode and the issue queue import the MD_OP_* values alongside the ALU ops.
package muldiv_pkg;

    localparam int unsigned MD_OP_WIDTH = 3;

    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL    = 3'd0;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULH   = 3'd1;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULHSU = 3'd2;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULHU  = 3'd3;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV    = 3'd4;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIVU   = 3'd5;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM    = 3'd6;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } md_state_e;

    typedef enum logic {
        ModeMul,
        ModeDiv
    } md_mode_e;

    function automatic logic md_is_div(input logic [MD_OP_WIDTH-1:0] op);
        return op[2];
    endfunction

    function automatic logic md_is_rem(input logic [MD_OP_WIDTH-1:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic md_op1_signed(input logic [MD_OP_WIDTH-1:0] op);
        return !(op == MD_OP_MULHU || op == MD_OP_DIVU || op == MD_OP_REMU);
    endfunction

    function automatic logic md_op2_signed(input logic [MD_OP_WIDTH-1:0] op);
        return (op == MD_OP_MUL || op == MD_OP_MULH || op == MD_OP_DIV || op == MD_OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or restoring divider, purely combinational.
// Divide packs {partial remainder, dividend/quotient} into the same 2*XLEN accumulator.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  md_mode_e          mode,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_next,
    output logic              q_bit
);

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] div_rem;
    logic            div_ok;

    // Multiply: add multiplicand into the high half when the multiplier LSB is set, then shift.
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);

    // Divide: trial subtraction on the XLEN+1-bit shifted partial remainder.
    assign div_shift = acc[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ok    = !div_diff[XLEN];
    assign div_rem   = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];

    always_comb begin
        acc_next = '0;
        q_bit    = 1'b0;
        unique case (mode)
            ModeMul: begin
                acc_next = {mul_sum, acc[XLEN-1:1]};
            end
            ModeDiv: begin
                // LSB is left vacant for the quotient bit.
                acc_next = {div_rem, acc[XLEN-2:0], 1'b0};
                q_bit    = div_ok;
            end
            default: begin
                acc_next = acc;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one bit per cycle, valid/ready in and out,
// ROB tag carried through, kill drops any in-flight or pending result.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MD_OP_WIDTH-1:0] in_op,
    input  logic [XLEN-1:0]        in1,
    input  logic [XLEN-1:0]        in2,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic                   kill,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_data,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int unsigned CntW = $clog2(XLEN);

    md_state_e              state_q, state_d;
    logic [MD_OP_WIDTH-1:0] op_q, op_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [2*XLEN-1:0]      acc_q, acc_d;
    logic [XLEN-1:0]        opnd_q, opnd_d;
    logic                   s1_q, s1_d;
    logic                   s2_q, s2_d;
    logic [XLEN-1:0]        out_data_q, out_data_d;
    logic [TAG_W-1:0]       out_tag_q, out_tag_d;

    // Accept-side decode of the incoming request.
    logic            neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] special_res;

    assign neg1 = md_op1_signed(in_op) & in1[XLEN-1];
    assign neg2 = md_op2_signed(in_op) & in2[XLEN-1];
    assign mag1 = neg1 ? -in1 : in1;
    assign mag2 = neg2 ? -in2 : in2;

    assign div_zero = md_is_div(in_op) && (in2 == '0);
    assign div_ovf  = (in_op == MD_OP_DIV || in_op == MD_OP_REM)
                      && (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (in2 == '1);

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = md_is_rem(in_op) ? in1 : '1;
        end else if (div_ovf) begin
            special_res = md_is_rem(in_op) ? '0 : in1;
        end
    end

    // Iteration datapath.
    md_mode_e          step_mode;
    logic [2*XLEN-1:0] step_next;
    logic              step_q_bit;
    logic [2*XLEN-1:0] step_acc;

    assign step_mode = md_is_div(op_q) ? ModeDiv : ModeMul;

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .mode    (step_mode),
        .acc     (acc_q),
        .opnd    (opnd_q),
        .acc_next(step_next),
        .q_bit   (step_q_bit)
    );

    // Quotient bit enters the vacated LSB; it is always 0 in multiply mode.
    assign step_acc = {step_next[2*XLEN-1:1], step_next[0] | step_q_bit};

    // Final sign fix-up applied on the CALC->DONE transition.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   final_res;

    assign prod_fix = (s1_q ^ s2_q) ? -step_acc : step_acc;
    assign quo      = step_acc[XLEN-1:0];
    assign rem      = step_acc[2*XLEN-1:XLEN];

    always_comb begin
        final_res = '0;
        unique case (op_q)
            MD_OP_MUL:                           final_res = prod_fix[XLEN-1:0];
            MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            MD_OP_DIV, MD_OP_DIVU:               final_res = (s1_q ^ s2_q) ? -quo : quo;
            MD_OP_REM, MD_OP_REMU:               final_res = s1_q ? -rem : rem;
            default:                             final_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        tag_d      = tag_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        out_data_d = out_data_q;
        out_tag_d  = out_tag_q;

        if (kill) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_d  = in_op;
                        tag_d = in_tag;
                        s1_d  = neg1;
                        s2_d  = neg2;
                        if (div_zero || div_ovf) begin
                            state_d    = StDone;
                            out_data_d = special_res;
                            out_tag_d  = in_tag;
                        end else begin
                            state_d = StCalc;
                            cnt_d   = CntW'(XLEN - 1);
                            if (md_is_div(in_op)) begin
                                acc_d  = {{XLEN{1'b0}}, mag1};
                                opnd_d = mag2;
                            end else begin
                                acc_d  = {{XLEN{1'b0}}, mag2};
                                opnd_d = mag1;
                            end
                        end
                    end
                end
                StCalc: begin
                    acc_d = step_acc;
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        state_d    = StDone;
                        out_data_d = final_res;
                        out_tag_d  = tag_q;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= '0;
            tag_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            out_data_q <= out_data_d;
            out_tag_q  <= out_tag_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases, kill/reset/backpressure scenarios and random ops
// checked against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in1, in2;
    logic [5:0]  in_tag;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_tag;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(
        .XLEN (32),
        .TAG_W(6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in1      (in1),
        .in2      (in2),
        .in_tag   (in_tag),
        .kill     (kill),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // RISC-V M-extension semantics from plain integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      ps;
        logic [63:0] pu;
        int          sa, sb, r;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
            3'd1: begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
            3'd2: begin ps = longint'(sa) * longint'({32'b0, b}); return ps[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                r = sa / sb;
                return r;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                r = sa % sb;
                return r;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op >= 3'd4 && b == 0) return 0;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
        return 32;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tg);
        int w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        in_op = op; in1 = a; in2 = b; in_tag = tg; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] tg, input logic [31:0] exp);
        int lat;
        issue(op, a, b, tg);
        wait_valid(lat);
        check("latency", 64'(lat), 64'(exp_latency(op, a, b)));
        check("data", 64'(out_data), 64'(exp));
        check("tag", 64'(out_tag), 64'(tg));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_pop", {62'b0, in_ready, out_valid}, 64'b10);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    vec_t dir [12] = '{
        '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB},
        '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000},
        '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
        '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF},
        '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD},
        '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF},
        '{3'd5, 32'd100,      32'd7,        32'd14},
        '{3'd7, 32'd100,      32'd7,        32'd2},
        '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF},
        '{3'd6, 32'd5,        32'd0,        32'd5},
        '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
        '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0}
    };

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          lat, seen;
        logic [31:0] hold_data;
        logic [5:0]  hold_tag;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [5:0]  rt;

        reset = 1'b1; in_valid = 1'b0; in_op = '0; in1 = '0; in2 = '0; in_tag = '0;
        kill = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_flags", {62'b0, in_ready, out_valid}, 64'b10);
        check("reset_data", 64'(out_data), 64'h0);
        check("reset_tag", 64'(out_tag), 64'h0);

        // Directed cases; first one carries tag 5.
        foreach (dir[i]) begin
            run_op(dir[i].op, dir[i].a, dir[i].b, (i == 0) ? 6'd5 : 6'(i + 10), dir[i].e);
        end

        // Kill at cycle t+10 of a DIV, then a fresh request at t+11.
        issue(3'd4, 32'd1000, 32'd7, 6'd11);
        repeat (9) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_calc_flags", {62'b0, in_ready, out_valid}, 64'b10);
        run_op(3'd5, 32'd50, 32'd5, 6'd22, 32'd10);

        // Kill while DONE with out_ready high drops the result.
        issue(3'd0, 32'd3, 32'd4, 6'd33);
        wait_valid(lat);
        check("pre_kill_valid", 64'(out_valid), 64'd1);
        kill = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0; out_ready = 1'b0;
        check("kill_done_flags", {62'b0, in_ready, out_valid}, 64'b10);

        // in_valid together with kill must not be accepted (special case would show at once).
        in_op = 3'd5; in1 = 32'd9; in2 = 32'd0; in_tag = 6'd44; in_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        check("kill_accept_flags", {62'b0, in_ready, out_valid}, 64'b10);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("kill_no_result", 64'(seen), 64'd0);

        // Backpressure: result and tag hold for 5 cycles with out_ready low.
        issue(3'd3, 32'h12345678, 32'h9ABCDEF0, 6'd55);
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'd32);
        hold_data = out_data;
        hold_tag  = out_tag;
        check("bp_data", 64'(hold_data), 64'(ref_model(3'd3, 32'h12345678, 32'h9ABCDEF0)));
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_hold", {24'b0, in_ready, out_valid, out_tag, out_data},
                  {24'b0, 1'b0, 1'b1, hold_tag, hold_data});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release", {62'b0, in_ready, out_valid}, 64'b10);

        // Reset mid-CALC.
        issue(3'd0, 32'd123, 32'd456, 6'd7);
        repeat (10) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_calc_flags", {62'b0, in_ready, out_valid}, 64'b10);
        check("rst_calc_data", 64'(out_data), 64'h0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("rst_no_stale", 64'(seen), 64'd0);

        // Random operations against the reference model.
        for (int n = 0; n < 150; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            rt  = 6'($urandom);
            run_op(rop, ra, rb, rt, ref_model(rop, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide execution unit implementing the RV32M/RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the single-cycle integer ALU in the execute stage. It accepts one operation at a time through a valid/ready handshake and returns the result with its ROB tag after a fixed iteration count. A kill input drops the in-flight operation on a pipeline flush.

## Interface
- `XLEN`, 32: operand and result width; must be a power of two, ≥ 8.
- `TAG_W`, 6: width of the ROB tag carried with each operation.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `in_valid`, in, 1: request valid.
- `in_ready`, out, 1: unit idle and able to accept.
- `in_op`, in, 3: operation in funct3 order: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `in1`, in, XLEN: rs1 operand (multiplicand / dividend).
- `in2`, in, XLEN: rs2 operand (multiplier / divisor).
- `in_tag`, in, TAG_W: ROB tag.
- `kill`, in, 1: flush; discards any in-flight or pending-output operation.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts result.
- `out_data`, out, XLEN: result.
- `out_tag`, out, TAG_W: tag of the result.

## Operation
- FSM states are IDLE, CALC and DONE.
  - `in_ready` = (state == IDLE), decoded combinationally from the state.
  - `out_valid` = (state == DONE).
- **Accept** happens when `in_valid && in_ready && !kill`. On accept the unit latches:
  - op and tag;
  - operand magnitudes and sign flags.
    - MUL/MULH/DIV/REM: both operands signed.
    - MULHSU: `in1` signed, `in2` unsigned.
    - MULHU/DIVU/REMU: both operands unsigned.
- **Special cases** are detected at accept and go IDLE→DONE directly, with the result precomputed:
  - Divisor zero: DIV/DIVU = all ones; REM/REMU = `in1`.
  - Signed overflow (`in1` = −2^(XLEN−1), `in2` = −1): DIV = `in1`; REM = 0.
- **Otherwise** the unit goes IDLE→CALC with the iteration counter set to XLEN−1. The counter is $clog2(XLEN) bits wide.
- **CALC** processes one bit per cycle.
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring step, with the partial remainder XLEN+1 bits wide.
  - When the counter reaches 0, transition to DONE. The final sign fix-up (two's-complement negate) is applied on that transition.
- **Result selection:**
  - MUL = low XLEN bits of the product.
  - MULH/MULHSU/MULHU = high XLEN bits of the product, signed per the operand rule above.
  - Product sign = s1 ^ s2.
  - Quotient sign = s1 ^ s2.
  - Remainder sign = s1.
- **DONE** holds `out_data`/`out_tag` stable until `out_ready`, then returns to IDLE.
- **kill** has priority over every other event.
  - In any state, kill forces IDLE on the next edge.
  - Kill suppresses accept in the same cycle.
  - A result present in DONE while kill is high is dropped, even if `out_ready` is high.
- Reset forces IDLE from any state, including mid-CALC. Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_tag` = 0.
  - `in_ready` = 1 from the first cycle after reset.

## Timing
- Accept at edge t gives:
  - Normal operation: CALC during cycles t+1 … t+XLEN; `out_valid` first high in cycle t+XLEN+1.
  - Special case: `out_valid` high in cycle t+1.
- With `out_ready` held high, the unit is back in IDLE one cycle after `out_valid`. Peak throughput is one operation per XLEN+2 cycles.
- There is no accept while in DONE: a new request waits for IDLE, and there is no bypass from `out_ready` to `in_ready`.
- `out_data`/`out_tag` are registered outputs. `in_ready`/`out_valid` are decoded from the state register only, never from inputs, so there are no combinational input→output paths.

## Structure
- The `MD_OP_*` encodings and `MD_OP_WIDTH` go in a shared header next to the ALU op definitions, for use by decode and the issue queue.
- One natural sub-module, `muldiv_step`: purely combinational single-iteration step.
  - Inputs: mode, accumulator / partial remainder, operand.
  - Outputs: next accumulator / remainder and quotient bit.
- The FSM, counter, sign handling and special-case detection stay in `muldiv_unit`.

## Test plan
- MUL `in1`=7, `in2`=0xFFFFFFFD, tag=5, accepted at t.
  - Expect `out_valid` at t+33 with `out_data`=0xFFFFFFEB and `out_tag`=5.
- High-part multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Division:
  - DIV −7 / 2 → 0xFFFFFFFD.
  - REM −7 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- Special cases, each with `out_valid` at t+1:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000.
  - REM 0x80000000/−1 → 0.
- Kill:
  - Kill at cycle t+10 of a DIV: `out_valid` never rises; `in_ready`=1 at t+11.
  - A new request at t+11 completes normally with its own tag.
  - Kill during DONE with `out_ready`=1: result dropped.
  - `in_valid`+kill in the same cycle: not accepted.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE.
  - `out_data`/`out_tag` stay stable and `in_ready` stays 0.
  - IDLE is reached one cycle after `out_ready`=1.
- Reset asserted mid-CALC: next cycle `out_valid`=0, `in_ready`=1, `out_data`=0, and no stale result appears later.
